// File: rtl/mn_matrix_pkg.sv
// Shared types and constants for the matrix buffer: FSM states, burst modes
// and the index-width helper used to size the row/column address fields.
package mn_matrix_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DUMP = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_DUMP = 1'b1;

  // Bits needed to index n entries; never less than one.
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mn_matrix_ram.sv
// Simple dual-port storage, synchronous read with read-before-write on a
// same-address collision; read data holds while re is low.
module mn_matrix_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mn_matrix_buf.sv
// Matrix buffer with bounds-checked random access and LOAD/DUMP streaming
// bursts; DUMP can emit the transpose of the stored matrix.
//
//   state  | meaning
//   IDLE   | random access allowed, waiting for start
//   LOAD   | accepting the in_valid stream in row-major order
//   DUMP   | emitting the out_valid stream (A or A')
//   FIN    | done pulse, back to IDLE next cycle
module mn_matrix_buf #(
  parameter int DATA_W = 32,
  parameter int MAX_M  = 16,
  parameter int MAX_N  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        m_dim,
  input  logic [7:0]        n_dim,
  input  logic              write,
  input  logic              read,
  input  logic              transpose,
  input  logic [7:0]        m_addr,
  input  logic [7:0]        n_addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              start,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import mn_matrix_pkg::*;

  localparam int RW = idx_w(MAX_M);
  localparam int CW = idx_w(MAX_N);
  localparam int AW = RW + CW;
  localparam logic [8:0] MAX_M_V = 9'(MAX_M);
  localparam logic [8:0] MAX_N_V = 9'(MAX_N);

  state_t      state_q, state_d;
  logic [7:0]  m_lat_q, m_lat_d, n_lat_q, n_lat_d;
  logic        tr_q, tr_d;
  logic [7:0]  cnt_o_q, cnt_o_d, cnt_i_q, cnt_i_d;
  logic        fetched_q, fetched_d;
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        zero_q, zero_d;

  logic              ram_re, ram_we;
  logic [AW-1:0]     ram_raddr, ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic [7:0]    rd_row, rd_col, lim_o, lim_i;
  logic          dims_ok, rd_ok, wr_ok, start_ok, swap, last_elem, step_en;
  logic [AW-1:0] seq_addr;

  mn_matrix_ram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata)
  );

  // Bounds are judged on the post-swap coordinates for reads.
  always_comb begin
    rd_row    = transpose ? n_addr : m_addr;
    rd_col    = transpose ? m_addr : n_addr;
    dims_ok   = ({1'b0, m_dim} <= MAX_M_V) && ({1'b0, n_dim} <= MAX_N_V);
    rd_ok     = dims_ok && (rd_row < m_dim) && (rd_col < n_dim);
    wr_ok     = dims_ok && (m_addr < m_dim) && (n_addr < n_dim);
    start_ok  = dims_ok && (m_dim != 8'd0) && (n_dim != 8'd0);
    swap      = tr_q && (state_q == S_DUMP);
    lim_o     = swap ? n_lat_q : m_lat_q;
    lim_i     = swap ? m_lat_q : n_lat_q;
    seq_addr  = swap ? {cnt_i_q[RW-1:0], cnt_o_q[CW-1:0]}
                     : {cnt_o_q[RW-1:0], cnt_i_q[CW-1:0]};
    last_elem = (cnt_o_q == lim_o - 8'd1) && (cnt_i_q == lim_i - 8'd1);
  end

  always_comb begin
    state_d     = state_q;
    m_lat_d     = m_lat_q;
    n_lat_d     = n_lat_q;
    tr_d        = tr_q;
    cnt_o_d     = cnt_o_q;
    cnt_i_d     = cnt_i_q;
    fetched_d   = fetched_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    zero_d      = zero_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ram_re      = 1'b0;
    ram_raddr   = {rd_row[RW-1:0], rd_col[CW-1:0]};
    ram_we      = 1'b0;
    ram_waddr   = {m_addr[RW-1:0], n_addr[CW-1:0]};
    ram_wdata   = data_in;
    step_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (read) begin
          if (rd_ok) begin
            ram_re = 1'b1;
            zero_d = 1'b0;
          end else begin
            zero_d = 1'b1;
            err_d  = 1'b1;
          end
        end
        if (write) begin
          if (wr_ok) ram_we = 1'b1;
          else       err_d  = 1'b1;
        end
        if (start) begin
          if (start_ok) begin
            m_lat_d   = m_dim;
            n_lat_d   = n_dim;
            tr_d      = transpose;
            cnt_o_d   = '0;
            cnt_i_d   = '0;
            fetched_d = 1'b0;
            busy_d    = 1'b1;
            if (mode == MODE_LOAD) begin
              state_d    = S_LOAD;
              in_ready_d = 1'b1;
            end else begin
              state_d = S_DUMP;
            end
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          ram_we    = 1'b1;
          ram_waddr = seq_addr;
          step_en   = 1'b1;
          if (last_elem) begin
            state_d    = S_FIN;
            in_ready_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      S_DUMP: begin
        // The RAM read register doubles as the one-deep output slot.
        if (!fetched_q && (!out_valid_q || out_ready)) begin
          ram_re      = 1'b1;
          ram_raddr   = seq_addr;
          zero_d      = 1'b0;
          out_valid_d = 1'b1;
          step_en     = 1'b1;
          if (last_elem) fetched_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (fetched_q) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (step_en && !last_elem) begin
      if (cnt_i_q == lim_i - 8'd1) begin
        cnt_i_d = '0;
        cnt_o_d = cnt_o_q + 8'd1;
      end else begin
        cnt_i_d = cnt_i_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      m_lat_q     <= '0;
      n_lat_q     <= '0;
      tr_q        <= 1'b0;
      cnt_o_q     <= '0;
      cnt_i_q     <= '0;
      fetched_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      m_lat_q     <= m_lat_d;
      n_lat_q     <= n_lat_d;
      tr_q        <= tr_d;
      cnt_o_q     <= cnt_o_d;
      cnt_i_q     <= cnt_i_d;
      fetched_q   <= fetched_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      zero_q      <= zero_d;
    end
  end

  assign data_out  = zero_q ? '0 : ram_rdata;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
